// File: rtl/decode_exec_unit.sv
// rtl/decode_exec_unit.sv - RV32 decoder, immediate generator and ALU with registered result
module decode_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic [3:0]      alu_sel,
  output logic            alu_src,
  output logic            mem_wen,
  output logic            reg_wen,
  output logic            branch,
  output logic            illegal,
  output logic [1:0]      imm_src,
  output logic            reg_wdata_src,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] alu_res,
  output logic            res_is_0,
  output logic [XLEN-1:0] alu_res_q,
  output logic            res_is_0_q
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_rs1;
  assign opcode     = instr[6:0];
  assign funct3     = instr[14:12];
  assign unused_rs1 = ^instr[19:15];

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_to_alu = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_to_alu = ALU_SLL;
      3'b010:  f3_to_alu = ALU_SLT;
      3'b011:  f3_to_alu = ALU_SLTU;
      3'b100:  f3_to_alu = ALU_XOR;
      3'b101:  f3_to_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_to_alu = ALU_OR;
      default: f3_to_alu = ALU_AND;
    endcase
  endfunction

  always_comb begin
    alu_sel       = ALU_ADD;
    alu_src       = 1'b0;
    mem_wen       = 1'b0;
    reg_wen       = 1'b0;
    branch        = 1'b0;
    illegal       = 1'b0;
    imm_src       = 2'b00;
    reg_wdata_src = 1'b0;
    case (opcode)
      OPC_OP: begin
        reg_wen = 1'b1;
        alu_sel = f3_to_alu(funct3, instr[30]);
      end
      OPC_OP_IMM: begin
        reg_wen = 1'b1;
        alu_src = 1'b1;
        alu_sel = f3_to_alu(funct3, (funct3 == 3'b101) && instr[30]);
      end
      OPC_LOAD: begin
        reg_wen       = 1'b1;
        alu_src       = 1'b1;
        reg_wdata_src = 1'b1;
      end
      OPC_STORE: begin
        mem_wen = 1'b1;
        alu_src = 1'b1;
        imm_src = 2'b01;
      end
      OPC_BRANCH: begin
        branch  = 1'b1;
        alu_sel = ALU_SUB;
        imm_src = 2'b10;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm_ext = '0;
    if (!illegal) begin
      case (imm_src)
        2'b00:   imm_ext = {{(XLEN-12){instr[31]}}, instr[31:20]};
        2'b01:   imm_ext = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
        2'b10:   imm_ext = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
        default: imm_ext = '0;
      endcase
    end
  end

  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  assign op_b  = alu_src ? imm_ext : rdata2;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_sel)
      ALU_ADD:  alu_res = rdata1 + op_b;
      ALU_SUB:  alu_res = rdata1 - op_b;
      ALU_AND:  alu_res = rdata1 & op_b;
      ALU_OR:   alu_res = rdata1 | op_b;
      ALU_XOR:  alu_res = rdata1 ^ op_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rdata1) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, rdata1 < op_b};
      ALU_SLL:  alu_res = rdata1 << shamt;
      ALU_SRL:  alu_res = rdata1 >> shamt;
      ALU_SRA:  alu_res = $signed(rdata1) >>> shamt;
      default:  alu_res = '0;
    endcase
  end

  assign res_is_0 = (alu_res == '0);

  logic [XLEN-1:0] alu_res_d;
  logic            res_is_0_d;
  assign alu_res_d  = alu_res;
  assign res_is_0_d = res_is_0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_res_q  <= '0;
      res_is_0_q <= 1'b1;
    end else begin
      alu_res_q  <= alu_res_d;
      res_is_0_q <= res_is_0_d;
    end
  end

endmodule

// File: tb/tb_decode_exec_unit.sv
// tb/tb_decode_exec_unit.sv - randomized and directed self-checking bench for decode_exec_unit
module tb_decode_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, rdata1, rdata2;
  logic [3:0]  alu_sel;
  logic        alu_src, mem_wen, reg_wen, branch, illegal, reg_wdata_src;
  logic [1:0]  imm_src;
  logic [31:0] imm_ext, alu_res, alu_res_q;
  logic        res_is_0, res_is_0_q;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  decode_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .rdata1(rdata1), .rdata2(rdata2),
    .alu_sel(alu_sel), .alu_src(alu_src), .mem_wen(mem_wen), .reg_wen(reg_wen),
    .branch(branch), .illegal(illegal), .imm_src(imm_src),
    .reg_wdata_src(reg_wdata_src), .imm_ext(imm_ext), .alu_res(alu_res),
    .res_is_0(res_is_0), .alu_res_q(alu_res_q), .res_is_0_q(res_is_0_q)
  );

  typedef struct {
    logic [3:0]  sel;
    logic        src, mwen, rwen, br, ill, wsrc;
    logic [1:0]  isrc;
    logic [31:0] imm, res;
    bit          imm_care, isrc_care;
  } exp_t;

  // funct3 -> operation code; the alternate form is one code above the base
  int base_code [8] = '{0, 7, 5, 6, 4, 8, 3, 2};

  function automatic logic [31:0] calc(input int sel, input logic [31:0] a, input logic [31:0] b);
    int s = int'(b[4:0]);
    logic [31:0] r;
    case (sel)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      6: r = (a < b) ? 32'd1 : 32'd0;
      7: r = a << s;
      8: r = a >> s;
      9: begin
        r = a >> s;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic exp_t model(input logic [31:0] in, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int f3 = int'(in[14:12]);
    logic [31:0] imm_i, imm_s, imm_b;
    imm_i = 32'($signed(in[31:20]));
    imm_s = 32'($signed({in[31:25], in[11:7]}));
    imm_b = 32'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
    e = '{sel: 4'd0, src: 1'b0, mwen: 1'b0, rwen: 1'b0, br: 1'b0, ill: 1'b0, wsrc: 1'b0,
          isrc: 2'd0, imm: 32'd0, res: 32'd0, imm_care: 1'b1, isrc_care: 1'b1};
    case (in[6:0])
      7'h33: begin
        e.rwen = 1; e.imm_care = 0; e.isrc_care = 0;
        e.sel = 4'(base_code[f3] + (((f3 == 0) || (f3 == 5)) && in[30] ? 1 : 0));
        e.res = calc(int'(e.sel), a, b);
      end
      7'h13: begin
        e.rwen = 1; e.src = 1; e.imm = imm_i;
        e.sel = 4'(base_code[f3] + ((f3 == 5) && in[30] ? 1 : 0));
        e.res = calc(int'(e.sel), a, imm_i);
      end
      7'h03: begin
        e.rwen = 1; e.src = 1; e.wsrc = 1; e.imm = imm_i;
        e.res = a + imm_i;
      end
      7'h23: begin
        e.mwen = 1; e.src = 1; e.isrc = 2'b01; e.imm = imm_s;
        e.res = a + imm_s;
      end
      7'h63: begin
        e.br = 1; e.sel = 4'd1; e.isrc = 2'b10; e.imm = imm_b;
        e.res = a - b;
      end
      default: begin
        e.ill = 1; e.imm_care = 0;
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (instr=0x%08h)", nm, act, exp, instr);
  endtask

  // Applies one cycle of inputs, checks combinational outputs, then the registered result
  task automatic step(input logic [31:0] in, input logic [31:0] a, input logic [31:0] b,
                      input logic rn);
    exp_t e;
    @(negedge clk);
    instr = in; rdata1 = a; rdata2 = b; rst_n = rn;
    #1;
    e = model(in, a, b);
    chk("alu_sel", 32'(alu_sel), 32'(e.sel));
    chk("alu_src", 32'(alu_src), 32'(e.src));
    chk("mem_wen", 32'(mem_wen), 32'(e.mwen));
    chk("reg_wen", 32'(reg_wen), 32'(e.rwen));
    chk("branch", 32'(branch), 32'(e.br));
    chk("illegal", 32'(illegal), 32'(e.ill));
    chk("reg_wdata_src", 32'(reg_wdata_src), 32'(e.wsrc));
    if (e.isrc_care) chk("imm_src", 32'(imm_src), 32'(e.isrc));
    if (e.imm_care) chk("imm_ext", imm_ext, e.imm);
    if (!e.ill) begin
      chk("alu_res", alu_res, e.res);
      chk("res_is_0", 32'(res_is_0), 32'(e.res == 32'd0));
    end
    @(posedge clk);
    #1;
    if (!rn) begin
      chk("alu_res_q_rst", alu_res_q, 32'd0);
      chk("res_is_0_q_rst", 32'(res_is_0_q), 32'd1);
    end else if (!e.ill) begin
      chk("alu_res_q", alu_res_q, e.res);
      chk("res_is_0_q", 32'(res_is_0_q), 32'(e.res == 32'd0));
    end
  endtask

  logic [6:0] opc_tab [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F};

  initial begin
    exp_t m;
    logic [31:0] r, a, b;
    int k;
    rst_n = 1'b0; instr = 32'h0000_0013; rdata1 = 32'd9; rdata2 = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_alu_res_q", alu_res_q, 32'd0);
    chk("reset_res_is_0_q", 32'(res_is_0_q), 32'd1);

    // pin the model to hand-computed values
    m = model(32'h4040_D093, 32'h8000_0000, 32'd0);
    chk("model_srai", m.res, 32'hF800_0000);
    m = model(32'hFE20_AE23, 32'd0, 32'd0);
    chk("model_sw_imm", m.imm, 32'hFFFF_FFFC);
    m = model(32'hFFF0_A093, 32'd0, 32'd0);
    chk("model_slti", m.res, 32'd0);

    step(32'h0050_0093, 32'd0, 32'h1234_5678, 1'b1);
    chk("addi_res_q", alu_res_q, 32'd5);
    chk("addi_imm", imm_ext, 32'd5);
    chk("addi_sel", 32'(alu_sel), 32'd0);
    step(32'h4020_8033, 32'd7, 32'd7, 1'b1);
    chk("sub_res", alu_res, 32'd0);
    chk("sub_zero", 32'(res_is_0), 32'd1);
    step(32'hFFF0_A093, 32'd0, 32'd0, 1'b1);
    chk("slti_imm", imm_ext, 32'hFFFF_FFFF);
    chk("slti_res", alu_res, 32'd0);
    step(32'hFFF0_B093, 32'd0, 32'd0, 1'b1);
    chk("sltiu_res", alu_res, 32'd1);
    step(32'hFE20_AE23, 32'd100, 32'd5, 1'b1);
    chk("sw_imm", imm_ext, 32'hFFFF_FFFC);
    chk("sw_imm_src", 32'(imm_src), 32'd1);
    chk("sw_mem_wen", 32'(mem_wen), 32'd1);
    step(32'h0020_8463, 32'd4, 32'd4, 1'b1);
    chk("beq_imm", imm_ext, 32'd8);
    chk("beq_branch", 32'(branch), 32'd1);
    chk("beq_sel", 32'(alu_sel), 32'd1);
    step(32'h4040_D093, 32'h8000_0000, 32'd0, 1'b1);
    chk("srai_res", alu_res, 32'hF800_0000);
    step(32'h0040_D093, 32'h8000_0000, 32'd0, 1'b1);
    chk("srli_res", alu_res, 32'h0800_0000);
    step(32'h0000_007F, 32'd1, 32'd2, 1'b1);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_reg_wen", 32'(reg_wen), 32'd0);
    step(32'h0050_0093, 32'd1, 32'd0, 1'b0);
    step(32'h0050_0093, 32'd1, 32'd0, 1'b1);
    chk("post_reset_q", alu_res_q, 32'd6);

    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      k = $urandom_range(0, 5);
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = 32'd0;
        2: b = 32'd0;
        default: ;
      endcase
      if (k == 5) step({r[31:7], 7'(r[6:0])}, a, b, ($urandom_range(0, 19) != 0));
      else        step({r[31:7], opc_tab[k]}, a, b, ($urandom_range(0, 19) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
